// File: rtl/apb_slave_if.sv
// APB4 completer front-end for the timer register block: setup -> CMD strobe (T1) -> WAIT response (T2 earliest).
// No backpressure of its own; stalls in WAIT for the register-block ack, bounded by TIMEOUT cycles.
module apb_slave_if #(
  parameter int                ADDR_W   = 12,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] MAX_ADDR = 12'h01C,
  parameter int                TIMEOUT  = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_W-1:0]     paddr,
  input  logic [DATA_W-1:0]     pwdata,
  input  logic [DATA_W/8-1:0]   pstrb,
  output logic                  pready,
  output logic [DATA_W-1:0]     prdata,
  output logic                  pslverr,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     addr,
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  output logic                  reg_pslverr,
  input  logic                  pready_w,
  input  logic [DATA_W-1:0]     rdata,
  input  logic [DATA_W-1:0]     tcr_in
);

  localparam logic [3:0] TMO = 4'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_WAIT} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_wstrb;
  logic                r_write;
  logic                r_derr;
  logic                r_terr;
  logic [3:0]          r_cnt;

  logic w_setup;
  logic w_derr;
  logic w_div_bad;
  logic w_tcr_chg;
  logic w_terr;
  logic w_tmo;
  logic w_done;
  logic w_pslv;
  logic w_tcr_unused;

  assign w_setup   = psel & ~penable;
  assign w_derr    = (paddr[1:0] != 2'b00) | (paddr > MAX_ADDR);
  assign w_div_bad = pstrb[1] & (pwdata[11:8] > 4'd8);
  // Once the timer runs, div_en and div_val are frozen; only timer_en may change.
  assign w_tcr_chg = tcr_in[0] & ((pstrb[0] & (pwdata[1] != tcr_in[1])) |
                                  (pstrb[1] & (pwdata[11:8] != tcr_in[11:8])));
  assign w_terr    = (paddr == '0) & pwrite & (pstrb[1] | pstrb[0]) & (w_div_bad | w_tcr_chg);

  assign w_tmo  = (r_cnt == TMO);
  assign w_done = r_derr | pready_w | w_tmo;
  assign w_pslv = r_derr | r_terr | (w_tmo & ~pready_w);

  assign w_tcr_unused = &{1'b0, tcr_in[DATA_W-1:12], tcr_in[7:2]};

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_setup) w_next = S_CMD;
      S_CMD:   w_next = psel ? S_WAIT : S_IDLE;
      S_WAIT:  if (!psel || w_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    wr_en       = 1'b0;
    rd_en       = 1'b0;
    reg_pslverr = 1'b0;
    pready      = 1'b0;
    pslverr     = 1'b0;
    prdata      = '0;
    case (r_state)
      S_CMD: begin
        wr_en       = r_write & ~r_derr;
        rd_en       = ~r_write & ~r_derr;
        reg_pslverr = r_write & ~r_derr & r_terr;
      end
      S_WAIT: begin
        if (w_done) begin
          pready  = 1'b1;
          pslverr = w_pslv;
          if (!r_write && !w_pslv) prdata = rdata;
        end
      end
      default: ;
    endcase
  end

  // Transfer latches load on the IDLE->CMD edge; the timeout counter saturates at TMO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_write <= 1'b0;
      r_derr  <= 1'b0;
      r_terr  <= 1'b0;
      r_cnt   <= '0;
    end else if (r_state == S_IDLE && w_setup) begin
      r_addr  <= paddr;
      r_wdata <= pwdata;
      r_wstrb <= pwrite ? pstrb : '0;
      r_write <= pwrite;
      r_derr  <= w_derr;
      r_terr  <= w_terr;
      r_cnt   <= '0;
    end else if (r_state == S_WAIT && !w_tmo) begin
      r_cnt   <= r_cnt + 4'd1;
    end
  end

  assign addr  = r_addr;
  assign wdata = r_wdata;
  assign wstrb = r_wstrb;

endmodule
